// File: rtl/sseg_display_scheduler.sv
// sseg_display_scheduler: round-robin, dwell-limited sharing of the 7-segment word between CPU and HW sources.
// Optional blink stage is compiled in with SSEG_SCHED_BLINK_EN.
module sseg_display_scheduler #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_data,
    output logic        cpu_ready,
    input  logic        hw_valid,
    input  logic [31:0] hw_data,
    output logic        hw_ready,
    input  logic        blink_en,
    output logic [31:0] sseg,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHOW_CPU, SHOW_HW} state_t;
    state_t state, state_nx;
    logic rr;
    logic cpu_xfer, hw_xfer;
    logic [31:0] dwell, disp, disp_nx;

    always_comb begin
        cpu_ready = 1'b1;
        hw_ready  = 1'b1;
        case (state)
            IDLE: begin
                cpu_ready = !hw_valid || !rr;
                hw_ready  = !cpu_valid || rr;
            end
            SHOW_CPU: begin
                hw_ready  = dwell == '0 && hw_valid;
                cpu_ready = !hw_ready;
            end
            SHOW_HW: begin
                cpu_ready = dwell == '0 && cpu_valid;
                hw_ready  = !cpu_ready;
            end
            default: ;
        endcase
        cpu_xfer = cpu_valid && cpu_ready;
        hw_xfer  = hw_valid && hw_ready;
        state_nx = cpu_xfer ? SHOW_CPU : hw_xfer ? SHOW_HW : state;
        disp_nx  = cpu_xfer ? cpu_data : hw_xfer ? hw_data : disp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr    <= 1'b0;
            dwell <= '0;
            disp  <= '1;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            disp  <= disp_nx;
            if (cpu_xfer || hw_xfer) begin
                owner <= hw_xfer;
                rr    <= cpu_xfer;
                dwell <= 32'(DWELL_CYCLES - 1);
            end else if (dwell != '0) begin
                dwell <= dwell - 32'd1;
            end
        end
    end

    assign busy = dwell != '0;

`ifdef SSEG_SCHED_BLINK_EN
    logic [31:0] bcnt;
    logic phase, phase_nx;
    logic bwrap;

    assign bwrap = bcnt == 32'(BLINK_CYCLES - 1);
    always_comb phase_nx = !blink_en ? 1'b1 : bwrap ? !phase : phase;

    // phase 1 = segments shown, 0 = blanked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
            sseg  <= '1;
        end else begin
            bcnt  <= (!blink_en || bwrap) ? '0 : bcnt + 32'd1;
            phase <= phase_nx;
            sseg  <= phase_nx ? disp_nx : '1;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = blink_en;
    assign sseg = disp;
`endif
endmodule
